// File: rtl/coax_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : coax_rx_ctrl
// Purpose  : Coax receive framing controller. It hunts for a start pattern of
//            START_BITS consecutive ones followed by a zero. It then receives
//            12-bit words: a sync bit, 10 data bits sent MSB first, and an
//            even-parity bit. A zero sync bit ends the message. Bit timing is
//            supervised by a timeout counter that runs while words are being
//            received.
// Ports    : clk               - single clock, rising edge
//            reset             - synchronous, active-high
//            rx_enable         - receiver on; low forces IDLE
//            bit_sample        - one-cycle strobe: bit_value is valid
//            bit_value         - received bit, qualified by bit_sample
//            bit_timer_enable  - enable to the external bit timer
//            data[9:0]         - last received data word
//            data_valid        - one-cycle pulse: data updated
//            parity_error      - qualifies data_valid
//            eom               - one-cycle pulse: end of message
//            timeout_error     - one-cycle pulse: bit timing lost
// Config   : COAX_RX_CTRL_PARITY_EN - when defined, parity is checked.
//            Otherwise the parity bit is consumed and parity_error is 0.
// Revision : 1.0 - initial release
// ============================================================================
module coax_rx_ctrl #(
    parameter int CLOCKS_PER_BIT = 8,
    parameter int START_BITS     = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_enable,
    input  logic       bit_sample,
    input  logic       bit_value,
    output logic       bit_timer_enable,
    output logic [9:0] data,
    output logic       data_valid,
    output logic       parity_error,
    output logic       eom,
    output logic       timeout_error
);

    localparam int c_timeout_clks = 2 * CLOCKS_PER_BIT;
    localparam int c_tmr_w        = $clog2(c_timeout_clks + 1);
    localparam int c_ones_w       = $clog2(START_BITS + 1);

    localparam logic [c_tmr_w-1:0]  c_timeout_cnt = c_tmr_w'(c_timeout_clks);
    localparam logic [c_ones_w-1:0] c_start_cnt   = c_ones_w'(START_BITS);
    localparam logic [3:0]          c_idx_sync    = 4'd0;
    localparam logic [3:0]          c_idx_parity  = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HUNT   = 2'd1,
        S_WORD   = 2'd2,
        S_RESYNC = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [c_ones_w-1:0] ones_q, ones_d;
    logic [3:0]          idx_q, idx_d;
    logic [c_tmr_w-1:0]  tmr_q, tmr_d;
    logic [9:0]          shift_q, shift_d;
    logic [9:0]          data_q, data_d;
    logic                dv_q, dv_d;
    logic                perr_q, perr_d;
    logic                eom_q, eom_d;
    logic                tmo_q, tmo_d;
    logic                bte_q, bte_d;

    logic                w_parity_err;
    logic [c_tmr_w-1:0]  w_tmr_inc;

    // On the parity strobe shift_q already holds all ten data bits, so the
    // parity check combines it with the live parity bit.
`ifdef COAX_RX_CTRL_PARITY_EN
    assign w_parity_err = ^{shift_q, bit_value};
`else
    assign w_parity_err = 1'b0;
`endif

    assign w_tmr_inc = tmr_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ones_d  = ones_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        shift_d = shift_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        perr_d  = 1'b0;
        eom_d   = 1'b0;
        tmo_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_enable) begin
                    state_d = S_HUNT;
                    ones_d  = '0;
                end
            end

            S_HUNT: begin
                if (bit_sample) begin
                    if (bit_value) begin
                        // Saturate so that a longer run of ones still
                        // qualifies as a start pattern.
                        if (ones_q != c_start_cnt) begin
                            ones_d = ones_q + 1'b1;
                        end
                    end else if (ones_q == c_start_cnt) begin
                        state_d = S_WORD;
                        ones_d  = '0;
                        idx_d   = c_idx_sync;
                        tmr_d   = '0;
                        shift_d = '0;
                    end else begin
                        ones_d = '0;
                    end
                end
            end

            S_WORD: begin
                if (bit_sample) begin
                    // A strobe always restarts the timeout, including when it
                    // lands on the cycle in which the limit would be reached.
                    tmr_d = '0;
                    if (idx_q == c_idx_sync) begin
                        if (bit_value) begin
                            idx_d = 4'd1;
                        end else begin
                            eom_d   = 1'b1;
                            state_d = S_HUNT;
                            ones_d  = '0;
                        end
                    end else if (idx_q == c_idx_parity) begin
                        data_d = shift_q;
                        dv_d   = 1'b1;
                        perr_d = w_parity_err;
                        idx_d  = c_idx_sync;
                    end else begin
                        shift_d = {shift_q[8:0], bit_value};
                        idx_d   = idx_q + 1'b1;
                    end
                end else if (w_tmr_inc == c_timeout_cnt) begin
                    tmo_d   = 1'b1;
                    state_d = S_RESYNC;
                    idx_d   = '0;
                    tmr_d   = '0;
                    shift_d = '0;
                end else begin
                    tmr_d = w_tmr_inc;
                end
            end

            S_RESYNC: begin
                state_d = S_HUNT;
                ones_d  = '0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Disabling the receiver overrides everything above: the partial
        // word is dropped and no pulse escapes.
        if (!rx_enable) begin
            state_d = S_IDLE;
            ones_d  = '0;
            idx_d   = '0;
            tmr_d   = '0;
            shift_d = '0;
            data_d  = data_q;
            dv_d    = 1'b0;
            perr_d  = 1'b0;
            eom_d   = 1'b0;
            tmo_d   = 1'b0;
        end

        // The timer enable is registered from the next state, so it follows
        // the state with no extra cycle of lag.
        bte_d = (state_d == S_HUNT) || (state_d == S_WORD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ones_q  <= '0;
            idx_q   <= '0;
            tmr_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            perr_q  <= 1'b0;
            eom_q   <= 1'b0;
            tmo_q   <= 1'b0;
            bte_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ones_q  <= ones_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            perr_q  <= perr_d;
            eom_q   <= eom_d;
            tmo_q   <= tmo_d;
            bte_q   <= bte_d;
        end
    end

    assign bit_timer_enable = bte_q;
    assign data             = data_q;
    assign data_valid       = dv_q;
    assign parity_error     = perr_q;
    assign eom              = eom_q;
    assign timeout_error    = tmo_q;

endmodule
`default_nettype wire

// File: doc/coax_rx_ctrl.md
COAX_RX_CTRL -- requirements
Module: coax_rx_ctrl

Interface
REQ-001 Parameter CLOCKS_PER_BIT, default 8: clk cycles per coax bit; sets the timeout.
REQ-002 Parameter START_BITS, default 5: consecutive 1 bits required before the start delimiter.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_enable  input  1  receiver on; low forces IDLE.
REQ-006 bit_sample  input  1  one-cycle strobe from the bit timer: a bit is valid this cycle.
REQ-007 bit_value  input  1  bit value, qualified by bit_sample.
REQ-008 bit_timer_enable  output  1  enable to the bit timer.
REQ-009 data  output  10  last received data word, MSB first on the line.
REQ-010 data_valid  output  1  one-cycle pulse: data updated.
REQ-011 parity_error  output  1  qualifies data_valid: received parity mismatch.
REQ-012 eom  output  1  one-cycle pulse: end of message.
REQ-013 timeout_error  output  1  one-cycle pulse: bit timing lost.

Function
REQ-014 States: IDLE, HUNT, WORD, RESYNC; state changes only on clk edges.
REQ-015 IDLE: bit_timer_enable=0; go to HUNT when rx_enable=1.
REQ-016 HUNT: bit_timer_enable=1; on bit_sample: bit 1 increments the ones counter (saturating at START_BITS), bit 0 with counter==START_BITS enters WORD, bit 0 with counter<START_BITS clears the counter.
REQ-017 WORD: bit_timer_enable=1; bit index 0..11 counts bit_sample strobes; index 0 is the sync bit.
REQ-018 Sync bit 0: pulse eom the following cycle, clear the ones counter, return to HUNT; no data_valid.
REQ-019 Sync bit 1: indices 1..10 shift into a 10-bit register MSB first; index 11 is the parity bit.
REQ-020 Word complete: on the cycle after the parity strobe, data updates, data_valid=1 for one cycle, and the machine stays in WORD with index=0 for the next word.
REQ-021 Parity is even over 10 data bits plus parity bit; parity_error=1 when the XOR of all 11 bits is 1; parity_error is meaningful only with data_valid and is 0 otherwise.
REQ-022 Timeout: in WORD, a counter counts clocks since the last bit_sample; reaching 2*CLOCKS_PER_BIT pulses timeout_error and enters RESYNC; the partial word is discarded.
REQ-023 RESYNC: bit_timer_enable=0 for exactly one cycle, then HUNT with the ones counter cleared.
REQ-024 bit_sample in the same cycle the timeout count would be reached: the sample wins; the counter clears; no timeout.
REQ-025 rx_enable=0 in any state: IDLE on the next edge, all counters cleared, partial word discarded, no pulse outputs generated.
REQ-026 bit_sample is ignored in IDLE and RESYNC.
REQ-027 At most one of data_valid, eom, timeout_error is asserted in any cycle.
REQ-028 data holds its value until the next data_valid.

Reset
REQ-029 With reset=1 at an edge: state=IDLE, every counter=0, data=0, bit_timer_enable=0, data_valid=0, parity_error=0, eom=0, timeout_error=0.
REQ-030 Reset has priority over rx_enable and bit_sample; reset mid-word discards the word without output pulses.

Configuration
REQ-031 Macro COAX_RX_CTRL_PARITY_EN defined: parity is checked per REQ-021.
REQ-032 Macro not defined: the parity bit is consumed and timed identically, and parity_error is constant 0.

Verification
REQ-033 Start, then one word: rx_enable=1, five 1s, 0, then sync 1, data 10'h2A5, parity 1 -> data_valid once, data=10'h2A5, parity_error=0.
REQ-034 Same word with parity 0, macro defined -> data_valid with parity_error=1; macro undefined -> parity_error=0.
REQ-035 Short start: four 1s then 0 -> stays in HUNT, no output; five 1s, 0, sync 0 -> eom single pulse, no data_valid.
REQ-036 Timeout: strobes stop after data bit 4 of a word -> timeout_error at 16 clocks after the last strobe (CLOCKS_PER_BIT=8), bit_timer_enable low one cycle, no data_valid.
REQ-037 Abort: rx_enable=0 at data bit 6, then start plus word 10'h3FF (parity 0) -> IDLE reached, only 10'h3FF reported.
REQ-038 Reset mid-word at data bit 3 -> all outputs 0 next cycle, no pulses, data=0.
